// File: rtl/pc_sequencer_pkg.sv
// Shared types and alignment helpers for the PC sequencer.
package pc_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HALT  = 2'd2
  } pc_state_e;

  // Number of low address bits that must be zero for a legal fetch address.
  localparam int unsigned ALIGN_BITS_IALIGN2 = 1;
  localparam int unsigned ALIGN_BITS_IALIGN4 = 2;

  function automatic int unsigned align_bits(input int unsigned ialign);
    return (ialign == 2) ? ALIGN_BITS_IALIGN2 : ALIGN_BITS_IALIGN4;
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch request channel between the PC sequencer and instruction memory.
interface pc_sequencer_if #(
  parameter int unsigned XLEN = 32
);
  logic            req_valid;
  logic [XLEN-1:0] req_addr;
  logic            req_ready;

  modport master (output req_valid, output req_addr, input req_ready);
  modport slave  (input req_valid, input req_addr, output req_ready);
endinterface

// File: rtl/pc_sequencer_next_sel.sv
// Next-pc priority mux: trap > redirect > handshake increment > hold.
module pc_next_sel
  import pc_pkg::*;
#(
  parameter int unsigned    XLEN        = 32,
  parameter logic [XLEN-1:0] TRAP_VECTOR = 'h0000_0100,
  parameter int unsigned    IALIGN      = 4
) (
  input  logic [XLEN-1:0] pc_i,
  input  logic            trap_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_target_i,
  input  logic            handshake_i,
  output logic [XLEN-1:0] pc_next_o,
  output logic            misalign_o
);

  localparam int unsigned AB = align_bits(IALIGN);

  logic unaligned;
  assign unaligned = |redirect_target_i[AB-1:0];

  // Select the next fetch address and flag misaligned redirects
  always_comb begin
    pc_next_o  = pc_i;
    misalign_o = 1'b0;
    if (trap_i) begin
      pc_next_o = TRAP_VECTOR;
    end else if (redirect_valid_i) begin
      if (unaligned) begin
        pc_next_o  = TRAP_VECTOR;
        misalign_o = 1'b1;
      end else begin
        pc_next_o = redirect_target_i;
      end
    end else if (handshake_i) begin
      pc_next_o = pc_i + XLEN'(IALIGN);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Instruction fetch PC sequencer: BOOT/FETCH/HALT control with a held
// request while memory back-pressures.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = 'h0000_0100,
  parameter int unsigned     IALIGN       = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_i,
  input  logic              halt_i,
  input  logic              redirect_valid_i,
  input  logic [XLEN-1:0]   redirect_target_i,
  input  logic              trap_i,
  pc_sequencer_if.master    fetch_if,
  output logic              issued_o,
  output logic [XLEN-1:0]   issued_pc_o,
  output logic              misalign_o
);

  pc_state_e       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            pending_q, pending_d;
  logic            issued_q, misalign_q;
  logic [XLEN-1:0] issued_pc_q;
  logic            handshake, trap_eff, redir_eff, misalign_d;

  // Trap and redirect are only honoured once out of BOOT.
  assign trap_eff  = trap_i & (state_q != ST_BOOT);
  assign redir_eff = redirect_valid_i & (state_q != ST_BOOT);
  assign handshake = fetch_if.req_valid & fetch_if.req_ready;

  pc_next_sel #(
    .XLEN        (XLEN),
    .TRAP_VECTOR (TRAP_VECTOR),
    .IALIGN      (IALIGN)
  ) u_next_sel (
    .pc_i              (pc_q),
    .trap_i            (trap_eff),
    .redirect_valid_i  (redir_eff),
    .redirect_target_i (redirect_target_i),
    .handshake_i       (handshake),
    .pc_next_o         (pc_d),
    .misalign_o        (misalign_d)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_BOOT;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BOOT:  state_d = ST_FETCH;
      ST_FETCH: begin
        if (trap_eff || redir_eff) state_d = ST_FETCH;
        else if (halt_i)           state_d = ST_HALT;
      end
      ST_HALT:  if (trap_eff || redir_eff) state_d = ST_FETCH;
      default:  state_d = ST_BOOT;
    endcase
  end

  // Request outputs, combinational from registers and stall
  always_comb begin
    fetch_if.req_valid = (state_q == ST_FETCH) && (pending_q || !stall_i);
    fetch_if.req_addr  = pc_q;
  end

  // Pending request tracking; halt entry drops an unaccepted request
  always_comb begin
    pending_d = pending_q;
    if (state_q != ST_FETCH || trap_eff || redir_eff || handshake) begin
      pending_d = 1'b0;
    end else if (halt_i) begin
      pending_d = 1'b0;
    end else if (fetch_if.req_valid && !fetch_if.req_ready) begin
      pending_d = 1'b1;
    end
  end

  // PC and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= RESET_VECTOR;
      pending_q   <= 1'b0;
      issued_q    <= 1'b0;
      issued_pc_q <= '0;
      misalign_q  <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      pending_q   <= pending_d;
      issued_q    <= handshake;
      misalign_q  <= misalign_d;
      if (handshake) issued_pc_q <= pc_q;
    end
  end

  assign issued_o    = issued_q;
  assign issued_pc_o = issued_pc_q;
  assign misalign_o  = misalign_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: IALIGN=4 main instance plus IALIGN=2 instance.
module tb_pc_sequencer;

  logic clk;
  logic rst_a, rst_b;
  logic stall_a, halt_a, redir_a, trap_a;
  logic [31:0] tgt_a;
  logic stall_b, halt_b, redir_b, trap_b;
  logic [31:0] tgt_b;
  logic iss_a, mis_a, iss_b, mis_b;
  logic [31:0] ipc_a, ipc_b;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  pc_sequencer_if #(.XLEN(32)) if_a ();
  pc_sequencer_if #(.XLEN(32)) if_b ();

  pc_sequencer #(.XLEN(32), .IALIGN(4)) dut_a (
    .clk(clk), .rst_n(rst_a), .stall_i(stall_a), .halt_i(halt_a),
    .redirect_valid_i(redir_a), .redirect_target_i(tgt_a), .trap_i(trap_a),
    .fetch_if(if_a.master), .issued_o(iss_a), .issued_pc_o(ipc_a), .misalign_o(mis_a)
  );

  pc_sequencer #(.XLEN(32), .IALIGN(2)) dut_b (
    .clk(clk), .rst_n(rst_b), .stall_i(stall_b), .halt_i(halt_b),
    .redirect_valid_i(redir_b), .redirect_target_i(tgt_b), .trap_i(trap_b),
    .fetch_if(if_b.master), .issued_o(iss_b), .issued_pc_o(ipc_b), .misalign_o(mis_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check valid/addr/issued of instance A in one go
  task automatic chk_a(input string tag, input logic v, input logic [31:0] a, input logic i);
    check_eq({tag, "_valid"}, 32'(if_a.req_valid), 32'(v));
    if (v) check_eq({tag, "_addr"}, if_a.req_addr, a);
    check_eq({tag, "_issued"}, 32'(iss_a), 32'(i));
  endtask

  initial begin
    rst_a = 1'b0; rst_b = 1'b0;
    stall_a = 0; halt_a = 0; redir_a = 0; trap_a = 0; tgt_a = '0;
    stall_b = 0; halt_b = 0; redir_b = 0; trap_b = 0; tgt_b = '0;
    if_a.req_ready = 1'b1;
    if_b.req_ready = 1'b1;
    #1;
    check_eq("rst_valid", 32'(if_a.req_valid), 32'd0);
    tick(); tick();
    check_eq("rst_issued", 32'(iss_a), 32'd0);
    check_eq("rst_ipc", ipc_a, 32'h0);
    check_eq("rst_mis", 32'(mis_a), 32'd0);
    check_eq("rst_pc", if_a.req_addr, 32'h0);

    // Boot then sequential fetch
    rst_a = 1'b1;
    check_eq("boot_valid", 32'(if_a.req_valid), 32'd0);
    tick(); chk_a("f0", 1, 32'h0, 0);
    tick(); chk_a("f4", 1, 32'h4, 1); check_eq("f4_ipc", ipc_a, 32'h0);
    tick(); chk_a("f8", 1, 32'h8, 1); check_eq("f8_ipc", ipc_a, 32'h4);

    // Back-pressure with stall toggling
    if_a.req_ready = 1'b0;
    tick(); chk_a("bp1", 1, 32'h8, 0);
    stall_a = 1; check_eq("bp1_stall_valid", 32'(if_a.req_valid), 32'd1);
    tick(); chk_a("bp2", 1, 32'h8, 0);
    stall_a = 0;
    tick(); chk_a("bp3", 1, 32'h8, 0);
    stall_a = 1; if_a.req_ready = 1'b1;
    tick(); chk_a("bp_acc", 0, 32'hC, 1); check_eq("bp_acc_ipc", ipc_a, 32'h8);
    check_eq("bp_acc_addr", if_a.req_addr, 32'hC);
    stall_a = 0;
    tick(); chk_a("fC", 1, 32'h10, 1); check_eq("fC_ipc", ipc_a, 32'hC);

    // Redirect while pending at 0x10
    if_a.req_ready = 1'b0;
    tick(); chk_a("pend10", 1, 32'h10, 0);
    redir_a = 1; tgt_a = 32'h200;
    tick(); chk_a("redir200", 1, 32'h200, 0);
    redir_a = 0; if_a.req_ready = 1'b1;
    tick(); chk_a("f204", 1, 32'h204, 1); check_eq("f204_ipc", ipc_a, 32'h200);

    // Misaligned redirect
    redir_a = 1; tgt_a = 32'h202; if_a.req_ready = 1'b0;
    tick(); chk_a("mis202", 1, 32'h100, 0); check_eq("mis202_pulse", 32'(mis_a), 32'd1);
    redir_a = 0; if_a.req_ready = 1'b1;
    tick(); chk_a("f104", 1, 32'h104, 1); check_eq("mis_clear", 32'(mis_a), 32'd0);

    // Trap beats misaligned redirect; coincident handshake still issues
    trap_a = 1; redir_a = 1; tgt_a = 32'h202;
    tick(); chk_a("trap", 1, 32'h100, 1);
    check_eq("trap_mis", 32'(mis_a), 32'd0); check_eq("trap_ipc", ipc_a, 32'h104);
    trap_a = 0; tgt_a = 32'hFFFF_FFFC;
    tick(); chk_a("toFFFC", 1, 32'hFFFF_FFFC, 1); check_eq("toFFFC_ipc", ipc_a, 32'h100);
    redir_a = 0;
    tick(); chk_a("wrap", 1, 32'h0, 1); check_eq("wrap_ipc", ipc_a, 32'hFFFF_FFFC);

    // Halt with accepted handshake, then redirect out of HALT
    halt_a = 1;
    tick(); chk_a("halt_enter", 0, 32'h4, 1); check_eq("halt_ipc", ipc_a, 32'h0);
    stall_a = 1;
    tick(); chk_a("halt_hold", 0, 32'h4, 0); check_eq("halt_pc", if_a.req_addr, 32'h4);
    stall_a = 0; redir_a = 1; tgt_a = 32'h40;
    tick(); chk_a("halt_exit", 1, 32'h40, 0);
    redir_a = 0; halt_a = 0;
    tick(); chk_a("f44", 1, 32'h44, 1); check_eq("f44_ipc", ipc_a, 32'h40);

    // Reset mid-handshake
    #2 rst_a = 1'b0;
    #1 check_eq("async_valid", 32'(if_a.req_valid), 32'd0);
    tick();
    check_eq("rst_mid_issued", 32'(iss_a), 32'd0);
    check_eq("rst_mid_ipc", ipc_a, 32'h0);
    check_eq("rst_mid_pc", if_a.req_addr, 32'h0);

    // IALIGN=2 instance
    rst_b = 1'b1;
    check_eq("b_boot", 32'(if_b.req_valid), 32'd0);
    tick(); check_eq("b_f0", if_b.req_addr, 32'h0); check_eq("b_v0", 32'(if_b.req_valid), 32'd1);
    tick(); check_eq("b_f2", if_b.req_addr, 32'h2); check_eq("b_ipc0", ipc_b, 32'h0);
    tick(); check_eq("b_f4", if_b.req_addr, 32'h4); check_eq("b_ipc2", ipc_b, 32'h2);
    redir_b = 1; tgt_b = 32'h202;
    tick(); check_eq("b_r202", if_b.req_addr, 32'h202); check_eq("b_r202_mis", 32'(mis_b), 32'd0);
    tgt_b = 32'h203;
    tick(); check_eq("b_r203", if_b.req_addr, 32'h100); check_eq("b_r203_mis", 32'(mis_b), 32'd1);
    redir_b = 0;
    tick(); check_eq("b_f102", if_b.req_addr, 32'h102); check_eq("b_ipc100", ipc_b, 32'h100);
    check_eq("b_iss", 32'(iss_b), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
